note_sequencer: RTL

Pattern-driven controller that sequences the team's square-wave tone generators and LFSR noise source. It holds a small writable step table (pitch half-period, duration, rest, noise flags) and steps through it at a programmable tempo. It drives a generator's half-period, gate and noise-enable so a melody plays without CPU or switch intervention. It sits between board I/O and one tone/noise voice.

---
 rtl/note_sequencer_if.sv | 31 +++
 rtl/note_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/note_sequencer_if.sv
// Control, table-write and voice-output bundle between board I/O and note_sequencer.
// master drives playback controls and table writes; slave is the sequencer itself.
interface note_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int HP_W   = 20
);
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] last_step;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [HP_W+9:0]   wr_data;
  logic              busy;
  logic [ADDR_W-1:0] step_idx;
  logic [HP_W-1:0]   half_period;
  logic              gate;
  logic              noise_en;
  logic              note_strobe;
  logic              done;

  modport master (
    output start, stop, loop_en, last_step, wr_en, wr_addr, wr_data,
    input  busy, step_idx, half_period, gate, noise_en, note_strobe, done
  );

  modport slave (
    input  start, stop, loop_en, last_step, wr_en, wr_addr, wr_data,
    output busy, step_idx, half_period, gate, noise_en, note_strobe, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Steps through a writable table of tone/rest/noise entries at a tempo of TICK_DIV clocks per tick.
// Define NOTE_SEQ_NOISE_EN to let each step's noise bit drive noise_en; otherwise noise_en stays 0.
module note_sequencer #(
  parameter int TICK_DIV  = 500000,
  parameter int GAP_TICKS = 1,
  parameter int ADDR_W    = 4,
  parameter int HP_W      = 20
) (
  input logic clk,
  input logic reset,
  note_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] PLAY    = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] ADVANCE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int CNT_W = (GAP_TICKS > 255) ? $clog2(GAP_TICKS + 1) : 8;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam bit HAS_GAP = (GAP_TICKS > 0);

`ifdef NOTE_SEQ_NOISE_EN
  localparam bit NOISE_ON = 1'b1;
`else
  localparam bit NOISE_ON = 1'b0;
`endif

  logic [HP_W+9:0]   step_table [2**ADDR_W];
  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [PS_W-1:0]   prescaler;
  logic [CNT_W-1:0]  cnt;
  logic              rest_q;
  logic              noise_q;
  logic [ADDR_W-1:0] step_idx;
  logic [HP_W-1:0]   half_period;
  logic              busy;
  logic              gate;
  logic              noise_en;
  logic              note_strobe;
  logic              done;

  logic [HP_W+9:0]   entry;
  logic [7:0]        entry_dur;
  logic [HP_W-1:0]   entry_hp;
  logic              entry_rest;
  logic              entry_noise;
  logic              tick;
  logic              last_tick;
  logic              rest_sel;
  logic              noise_sel;

  assign entry       = step_table[step_idx];
  assign entry_dur   = entry[7:0];
  assign entry_hp    = entry[HP_W+7:8];
  assign entry_rest  = entry[HP_W+8];
  assign entry_noise = entry[HP_W+9];

  assign tick      = (prescaler == PS_LAST);
  assign last_tick = tick && (cnt == CNT_W'(1));

  // In LOAD the outputs for the coming PLAY come straight from the table entry.
  assign rest_sel  = (state == LOAD) ? entry_rest  : rest_q;
  assign noise_sel = (state == LOAD) ? entry_noise : noise_q;

  assign bus.busy        = busy;
  assign bus.step_idx    = step_idx;
  assign bus.half_period = half_period;
  assign bus.gate        = gate;
  assign bus.noise_en    = noise_en;
  assign bus.note_strobe = note_strobe;
  assign bus.done        = done;

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      step_table[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = LOAD;
      LOAD:    next_state = (entry_dur == 8'd0) ? ADVANCE : PLAY;
      PLAY:    if (last_tick) next_state = HAS_GAP ? GAP : ADVANCE;
      GAP:     if (last_tick) next_state = ADVANCE;
      ADVANCE: next_state = (step_idx == bus.last_step && !bus.loop_en) ? DONE : LOAD;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (bus.stop) begin
      next_state = IDLE;
    end
  end

  // Every output is a register loaded from next_state, so stop and reset take effect cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prescaler   <= '0;
      cnt         <= '0;
      rest_q      <= 1'b0;
      noise_q     <= 1'b0;
      step_idx    <= '0;
      half_period <= '0;
      busy        <= 1'b0;
      gate        <= 1'b0;
      noise_en    <= 1'b0;
      note_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= next_state;
      busy        <= (next_state != IDLE);
      done        <= (next_state == DONE);
      note_strobe <= (state == LOAD) && (next_state == PLAY);
      gate        <= (next_state == PLAY) && !rest_sel;
      noise_en    <= (next_state == PLAY) && noise_sel && NOISE_ON;

      if ((next_state == state) && (state == PLAY || state == GAP)) begin
        prescaler <= tick ? '0 : prescaler + PS_W'(1);
      end else begin
        prescaler <= '0;
      end

      case (state)
        IDLE: begin
          if (next_state == LOAD) step_idx <= '0;
        end
        LOAD: begin
          if (next_state == PLAY) begin
            half_period <= entry_hp;
            rest_q      <= entry_rest;
            noise_q     <= entry_noise;
            cnt         <= CNT_W'(entry_dur);
          end
        end
        PLAY: begin
          if (tick) begin
            cnt <= (next_state == GAP) ? CNT_W'(GAP_TICKS) : cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (tick) cnt <= cnt - CNT_W'(1);
        end
        ADVANCE: begin
          if (next_state == LOAD) begin
            step_idx <= (step_idx == bus.last_step) ? '0 : step_idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
